// File: rtl/inst_fetch_if.sv
// Fetch unit bus: flush/redirect from the ROB, memory read port and decoder handshake.
interface inst_fetch_if;
  logic        clear;
  logic [31:0] clear_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        to_dec_valid;
  logic [31:0] to_dec_pc;
  logic [31:0] to_dec_inst;
  logic        from_dec_ready;

  // Fetch unit side
  modport master (
    input  clear, clear_pc, mem_ack, mem_data, from_dec_ready,
    output mem_req, mem_addr, to_dec_valid, to_dec_pc, to_dec_inst
  );

  // Environment side (ROB, memory port, decoder)
  modport slave (
    output clear, clear_pc, mem_ack, mem_data, from_dec_ready,
    input  mem_req, mem_addr, to_dec_valid, to_dec_pc, to_dec_inst
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding word read, 2^QUEUE_LOG-entry {pc, inst}
// queue toward the decoder, flush/redirect on clear.
// Optional macro IFETCH_JAL_PREDICT_EN: follow JAL targets when computing the next fetch PC.
module inst_fetch #(
  parameter int unsigned QUEUE_LOG = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  inst_fetch_if.master bus
);

  localparam int unsigned DEPTH = 1 << QUEUE_LOG;
  localparam int unsigned CNT_W = QUEUE_LOG + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [QUEUE_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 mem_req_q, mem_req_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic                 dec_valid_q, dec_valid_d;
  logic [31:0]          dec_pc_q, dec_pc_d;
  logic [31:0]          dec_inst_q, dec_inst_d;
  logic [31:0]          q_pc_q   [DEPTH];
  logic [31:0]          q_inst_q [DEPTH];
  logic                 push_c, pop_c;
  logic [31:0]          next_pc_c;

`ifdef IFETCH_JAL_PREDICT_EN
  logic [31:0] jal_off_c;

  // Next fetch PC: JAL target for a fetched JAL, sequential otherwise
  always_comb begin
    jal_off_c = {{11{bus.mem_data[31]}}, bus.mem_data[31], bus.mem_data[19:12],
                 bus.mem_data[20], bus.mem_data[30:21], 1'b0};
    next_pc_c = (bus.mem_data[6:0] == 7'b1101111) ? fetch_pc_q + jal_off_c
                                                  : fetch_pc_q + 32'd4;
  end
`else
  // Next fetch PC: always sequential
  assign next_pc_c = fetch_pc_q + 32'd4;
`endif

  // Memory-port FSM, queue pointers and decoder-facing head registers
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    dec_valid_d = dec_valid_q;
    dec_pc_d    = dec_pc_q;
    dec_inst_d  = dec_inst_q;
    push_c      = 1'b0;
    pop_c       = 1'b0;

    if (rdy_in) begin
      pop_c = dec_valid_q && bus.from_dec_ready && !bus.clear;

      case (state_q)
        // Issue only when a slot is guaranteed for the result
        ST_IDLE: begin
          if (!bus.clear && (count_q < CNT_W'(DEPTH))) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
            state_d    = ST_WAIT;
          end
        end
        // A clear with a same-cycle ack drops the word and finishes the read
        ST_WAIT: begin
          if (bus.mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
            if (!bus.clear) begin
              push_c     = 1'b1;
              fetch_pc_d = next_pc_c;
            end
          end else if (bus.clear) begin
            state_d = ST_DISCARD;
          end
        end
        // Read of a flushed path: hold the request until it completes, drop data
        ST_DISCARD: begin
          if (bus.mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      endcase

      if (pop_c)  head_d = head_q + QUEUE_LOG'(1);
      if (push_c) tail_d = tail_q + QUEUE_LOG'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

      if (bus.clear) begin
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        fetch_pc_d = bus.clear_pc;
      end

      // Head registers: bypass a push that lands directly at the head slot
      dec_valid_d = (count_d != '0);
      if (push_c && (count_d == CNT_W'(1))) begin
        dec_pc_d   = fetch_pc_q;
        dec_inst_d = bus.mem_data;
      end else if (count_d != '0) begin
        dec_pc_d   = q_pc_q[head_d];
        dec_inst_d = q_inst_q[head_d];
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      dec_valid_q <= 1'b0;
      dec_pc_q    <= '0;
      dec_inst_q  <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      dec_valid_q <= dec_valid_d;
      dec_pc_q    <= dec_pc_d;
      dec_inst_q  <= dec_inst_d;
    end
  end

  // Queue storage, written at the tail on each accepted fetch
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_inst_q[i] <= '0;
      end
    end else if (push_c) begin
      q_pc_q[tail_q]   <= fetch_pc_q;
      q_inst_q[tail_q] <= bus.mem_data;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.to_dec_valid = dec_valid_q;
  assign bus.to_dec_pc    = dec_pc_q;
  assign bus.to_dec_inst  = dec_inst_q;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit of the out-of-order RISC-V core. It issues word reads to the memory/icache port and buffers fetched instructions with their PCs in a small FIFO. It presents one instruction at a time to the decoder through a valid/ready pair (`to_dec_valid` / `from_dec_ready`). On `clear` (mispredict/flush from the ROB) it redirects to a new PC.

## Interface
Parameters:
- QUEUE_LOG, 2, log2 of instruction queue depth (depth = 4)
- RESET_PC, 32'h0, fetch PC after reset

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global enable; when 0 all state holds, outputs hold
- clear  input  1  flush request from ROB, single-cycle pulse
- clear_pc  input  32  redirect PC, valid with clear
- mem_req  output  1  read request to memory port
- mem_addr  output  32  word address (byte PC, bits[1:0]=0)
- mem_ack  input  1  one-cycle pulse, read done
- mem_data  input  32  instruction word, valid with mem_ack
- to_dec_valid  output  1  queue head valid (decoder's from_if)
- to_dec_pc  output  32  PC of queue head
- to_dec_inst  output  32  instruction of queue head
- from_dec_ready  input  1  decoder can accept (decoder's to_if)

## Operation
- State machine over the memory port:
  - IDLE: if free slots > 0, assert mem_req with mem_addr=fetch_pc, go to WAIT.
  - WAIT: hold mem_req and mem_addr stable. On mem_ack, push {fetch_pc, mem_data}, advance fetch_pc, deassert mem_req, go to IDLE.
  - DISCARD: entered on clear while in WAIT. Keep mem_req until mem_ack, drop the data, go to IDLE.
- Free slots = depth − count − (state==WAIT). A request is never issued unless its result has a guaranteed slot.
- Next PC: fetch_pc+4, modulo 2^32.
- Decoder transfer: occurs at a posedge with to_dec_valid && from_dec_ready; it pops the head. to_dec_pc and to_dec_inst are driven from the head registers. They are undefined when to_dec_valid=0, but must not change while valid=1 and ready=0.
- Simultaneous push and pop: count is unchanged; both happen.
- Full queue: no request is issued; a pending WAIT is still accepted because its slot was reserved.
- Empty queue: to_dec_valid=0; a pop is impossible.
- Pointer wrap: head and tail are QUEUE_LOG-bit pointers that wrap naturally. count is QUEUE_LOG+1 bits.
- clear has the highest priority:
  - Empties the queue: head=tail=0, count=0.
  - Sets fetch_pc=clear_pc.
  - Suppresses any same-cycle push and pop.
  - In WAIT it goes to DISCARD. A same-cycle mem_ack is treated as already discarded, so it goes to IDLE.
  - In IDLE it stays in IDLE.
  - In DISCARD it stays in DISCARD.
- rdy_in=0 freezes all state. An ack arriving while rdy_in=0 is the memory controller's responsibility to hold; the memory controller also honours rdy_in.

## Timing
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC
  - count=0, head=tail=0
  - mem_req=0, mem_addr=0
  - to_dec_valid=0, to_dec_pc=0, to_dec_inst=0
- mem_req rises at the first posedge after reset release, when state is IDLE.
- Latency: an ack at posedge N makes the entry visible at to_dec_valid after edge N. The decoder can consume it at edge N+1.
- Minimum fetch issue interval: 2 cycles (ack edge → IDLE → request edge).
- Reset asserted mid-transaction: everything returns to reset values immediately. Any later mem_ack is ignored in IDLE.
- An ack in IDLE (spurious) is ignored.

## Configuration
- `IFETCH_JAL_PREDICT_EN`
  - Defined: on a push where mem_data[6:0]==7'b1101111 (JAL), next fetch_pc = fetch_pc + sext({mem_data[31], mem_data[19:12], mem_data[20], mem_data[30:21], 1'b0}). All other instructions advance by +4. The JAL is still pushed to the decoder unchanged.
  - Undefined: next PC is always fetch_pc+4.
  - clear behaviour is identical in both builds.

## Test plan
- Reset, RESET_PC=0, memory acks in 3 cycles, decoder always ready → addresses 0,4,8,12 requested in order; decoder sees pc 0,4,8,12 with matching words.
- Decoder ready held 0 → exactly 4 entries fetched, then mem_req stays 0. to_dec_pc=0 stays stable until ready=1, then pc 0,4,8,12 drain, and fetching resumes at 16.
- clear with clear_pc=0x100 while in WAIT at addr 0x8 → ack for 0x8 is dropped, queue empty the next cycle, next request addr=0x100, first decoded pc=0x100.
- clear in the same cycle as mem_ack and a decoder pop → no push, no duplicate pop, count=0, next request at clear_pc.
- Macro defined: word at 0x0 = 0x0100006F (jal x0,+16) → next request addr=0x10. Macro undefined → next request addr=0x4.
- Reset pulse during WAIT, then an ack arrives → ack ignored, to_dec_valid=0, fresh request at RESET_PC.
